// File: rtl/ife_block_dispatcher.sv
// Consumer end of the IFE block queue: holds one instruction block and hands it
// to the next idle execution core, chosen round-robin, then tracks that core as busy until it reports done.
module ife_block_dispatcher #(
  parameter int BLOCK_ID_WIDTH = 8,
  parameter int INSTR_WIDTH    = 32,
  parameter int BLOCK_SIZE     = 4,
  parameter int NUM_CORES      = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [BLOCK_ID_WIDTH-1:0]         block_id_in,
  input  logic [BLOCK_SIZE*INSTR_WIDTH-1:0] block_in,
  input  logic                              valid_in,
  output logic                              ready_out,
  output logic [NUM_CORES-1:0]              core_valid,
  input  logic [NUM_CORES-1:0]              core_ready,
  output logic [BLOCK_ID_WIDTH-1:0]         core_block_id,
  output logic [BLOCK_SIZE*INSTR_WIDTH-1:0] core_block,
  input  logic [NUM_CORES-1:0]              core_done,
  output logic [NUM_CORES-1:0]              core_busy,
  output logic [CNT_WIDTH-1:0]              dispatch_count
);

  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int BW = BLOCK_SIZE * INSTR_WIDTH;

  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_WAIT_CORE = 2'd1,
    S_OFFER     = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [NUM_CORES-1:0]      r_busy;
  logic [NUM_CORES-1:0]      w_busy_nxt;
  logic [CW-1:0]             r_rr_ptr;
  logic [CW-1:0]             w_rr_nxt;
  logic [CW-1:0]             r_sel;
  logic [CW-1:0]             w_sel_nxt;
  logic [CW-1:0]             w_idle_sel;
  logic                      w_idle_found;
  logic [CW:0]               w_idx;
  logic [NUM_CORES-1:0]      w_sel_onehot;
  logic [CNT_WIDTH-1:0]      r_count;
  logic [CNT_WIDTH-1:0]      w_count_nxt;
  logic [BLOCK_ID_WIDTH-1:0] r_hold_id;
  logic [BW-1:0]             r_hold_block;
  logic                      w_load;
  logic                      w_accept;

  // Round-robin search: first idle core at rr_ptr, rr_ptr+1, ... modulo NUM_CORES.
  // The index carries one spare bit so rr_ptr+k cannot overflow before the wrap.
  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no latch is inferred.
    w_idle_found = 1'b0;
    w_idle_sel   = '0;
    w_idx        = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (CW+1)'(k);
      if (w_idx >= (CW+1)'(NUM_CORES)) w_idx = w_idx - (CW+1)'(NUM_CORES);
      if (!w_idle_found && !r_busy[w_idx[CW-1:0]]) begin
        w_idle_found = 1'b1;
        w_idle_sel   = w_idx[CW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_onehot        = '0;
    w_sel_onehot[r_sel] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rr_nxt    = r_rr_ptr;
    w_count_nxt = r_count;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    ready_out   = 1'b0;
    core_valid  = '0;
    unique case (r_state)
      S_EMPTY: begin
        ready_out = !flush;
        if (valid_in && !flush) begin
          w_load      = 1'b1;
          w_state_nxt = S_WAIT_CORE;
        end
      end
      S_WAIT_CORE: begin
        if (w_idle_found) begin
          w_sel_nxt   = w_idle_sel;
          w_state_nxt = S_OFFER;
        end
      end
      S_OFFER: begin
        // A flush masks the offer in the same cycle so no core can take a dropped block.
        core_valid = flush ? '0 : w_sel_onehot;
        if (!flush && core_ready[r_sel]) begin
          w_accept    = 1'b1;
          w_rr_nxt    = (r_sel == CW'(NUM_CORES - 1)) ? '0 : r_sel + CW'(1);
          w_count_nxt = r_count + CNT_WIDTH'(1);
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (flush) w_state_nxt = S_EMPTY;
  end

  // Done clears first, then a same-cycle handshake sets, so set wins on a collision.
  always_comb begin
    w_busy_nxt = r_busy & ~core_done;
    if (w_accept) w_busy_nxt[r_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_busy       <= '0;
      r_rr_ptr     <= '0;
      r_sel        <= '0;
      r_count      <= '0;
      r_hold_id    <= '0;
      r_hold_block <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state  <= w_state_nxt;
      r_busy   <= w_busy_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_sel    <= w_sel_nxt;
      r_count  <= w_count_nxt;
      if (w_load) begin
        r_hold_id    <= block_id_in;
        r_hold_block <= block_in;
      end
    end
  end

  assign core_block_id  = r_hold_id;
  assign core_block     = r_hold_block;
  assign core_busy      = r_busy;
  assign dispatch_count = r_count;

endmodule

// File: tb/tb_ife_block_dispatcher.sv
// Directed bench for ife_block_dispatcher: expected dispatches are queued when a block
// is pushed and compared against each core handshake; status outputs are checked at key points.
module tb_ife_block_dispatcher;

  localparam int IDW = 8;
  localparam int BW  = 128;
  localparam int NC  = 3;
  localparam int CNW = 8;  // narrow counter so the wrap is reachable in a short run

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic [IDW-1:0] block_id_in;
  logic [BW-1:0]  block_in;
  logic           valid_in;
  logic           ready_out;
  logic [NC-1:0]  core_valid;
  logic [NC-1:0]  core_ready;
  logic [IDW-1:0] core_block_id;
  logic [BW-1:0]  core_block;
  logic [NC-1:0]  core_done;
  logic [NC-1:0]  core_busy;
  logic [CNW-1:0] dispatch_count;

  ife_block_dispatcher #(
    .BLOCK_ID_WIDTH(IDW), .INSTR_WIDTH(32), .BLOCK_SIZE(4), .NUM_CORES(NC), .CNT_WIDTH(CNW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .block_id_in(block_id_in), .block_in(block_in), .valid_in(valid_in), .ready_out(ready_out),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_block_id(core_block_id), .core_block(core_block),
    .core_done(core_done), .core_busy(core_busy), .dispatch_count(dispatch_count)
  );

  typedef struct {
    int             core;
    logic [IDW-1:0] id;
    logic [BW-1:0]  blk;
  } exp_t;

  exp_t           sb_q[$];
  int             n_vec;
  int             n_bad;
  logic [CNW-1:0] exp_count;
  logic [BW-1:0]  last_blk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sampled just after the negedge: a handshake seen here completes on the next posedge.
  task automatic sb_sample();
    exp_t         e;
    logic [NC-1:0] oh;
    if (rst_n && |(core_valid & core_ready)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_dispatch", BW'(core_valid), BW'(0));
      end else begin
        e  = sb_q.pop_front();
        oh = NC'(1 << e.core);
        check("sb_core", BW'(core_valid), BW'(oh));
        check("sb_id", BW'(core_block_id), BW'(e.id));
        check("sb_block", core_block, e.blk);
      end
      exp_count = exp_count + CNW'(1);
    end
  endtask

  task automatic nxt();
    #1;
    sb_sample();
    @(negedge clk);
  endtask

  task automatic push(input logic [IDW-1:0] id, input int exp_core, input bit expect_dispatch);
    int   w;
    exp_t e;
    w = 0;
    while (!ready_out && w < 50) begin
      nxt();
      w++;
    end
    check("push_ready_timeout", BW'(ready_out), BW'(1));
    last_blk    = {$urandom, $urandom, $urandom, $urandom};
    valid_in    = 1'b1;
    block_id_in = id;
    block_in    = last_blk;
    if (expect_dispatch) begin
      e.core = exp_core;
      e.id   = id;
      e.blk  = last_blk;
      sb_q.push_back(e);
    end
    nxt();
    valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 50) begin
      nxt();
      w++;
    end
    check("drain_timeout", BW'(sb_q.size()), BW'(0));
    nxt();
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    exp_count   = '0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    valid_in    = 1'b0;
    block_id_in = '0;
    block_in    = '0;
    core_ready  = '0;
    core_done   = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_core_valid", BW'(core_valid), BW'(0));
    check("rst_busy", BW'(core_busy), BW'(0));
    check("rst_count", BW'(dispatch_count), BW'(0));
    check("rst_hold_id", BW'(core_block_id), BW'(0));
    rst_n = 1'b1;
    #1;
    check("rst_ready_out", BW'(ready_out), BW'(1));
    @(negedge clk);

    // Three blocks go to cores 0,1,2 in order; first one checks the two-cycle latency
    core_ready = 3'b111;
    push(8'h10, 0, 1'b1);
    check("lat_wait_no_offer", BW'(core_valid), BW'(0));
    check("lat_wait_not_ready", BW'(ready_out), BW'(0));
    nxt();
    check("lat_offer_core0", BW'(core_valid), BW'(3'b001));
    push(8'h11, 1, 1'b1);
    push(8'h12, 2, 1'b1);
    wait_drain();
    check("all_busy", BW'(core_busy), BW'(3'b111));
    check("count_3", BW'(dispatch_count), BW'(exp_count));
    check("count_3_const", BW'(dispatch_count), BW'(3));

    // All busy: block waits with back-pressure until core 1 reports done
    push(8'h13, 1, 1'b1);
    nxt();
    nxt();
    check("held_ready_low", BW'(ready_out), BW'(0));
    check("held_no_offer", BW'(core_valid), BW'(0));
    core_done = 3'b010;
    nxt();
    core_done = 3'b000;
    check("done_busy_cleared", BW'(core_busy), BW'(3'b101));
    check("done_no_offer_yet", BW'(core_valid), BW'(0));
    nxt();
    check("done_offer_core1", BW'(core_valid), BW'(3'b010));
    wait_drain();
    check("refill_busy", BW'(core_busy), BW'(3'b111));
    check("count_4", BW'(dispatch_count), BW'(exp_count));

    // Offer to core 0 held while core 0 stalls; core 2 ready must be ignored
    core_done = 3'b011;
    nxt();
    core_done  = 3'b000;
    core_ready = 3'b100;
    push(8'h14, 0, 1'b1);
    nxt();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", BW'(core_valid), BW'(3'b001));
      check("stall_id", BW'(core_block_id), BW'(8'h14));
      check("stall_block", core_block, last_blk);
      check("stall_busy", BW'(core_busy), BW'(3'b100));
      nxt();
    end
    core_ready = 3'b001;
    wait_drain();
    check("stall_accept_busy", BW'(core_busy), BW'(3'b101));
    check("count_5", BW'(dispatch_count), BW'(exp_count));

    // Flush in OFFER: offer masked immediately, block dropped, count and busy kept
    core_ready = 3'b000;
    push(8'h15, 1, 1'b0);
    nxt();
    check("pre_flush_offer", BW'(core_valid), BW'(3'b010));
    flush = 1'b1;
    #1;
    check("flush_valid_masked", BW'(core_valid), BW'(0));
    check("flush_ready_low", BW'(ready_out), BW'(0));
    nxt();
    flush = 1'b0;
    #1;
    check("flush_empty_ready", BW'(ready_out), BW'(1));
    check("flush_no_offer", BW'(core_valid), BW'(0));
    check("flush_count", BW'(dispatch_count), BW'(exp_count));
    check("flush_count_const", BW'(dispatch_count), BW'(5));
    check("flush_busy", BW'(core_busy), BW'(3'b101));

    // Counter wrap: cores finish at once, so round-robin continues from core 1
    core_done  = 3'b111;
    core_ready = 3'b111;
    nxt();
    for (int i = 0; i < 251; i++) push(IDW'(i), (1 + i) % 3, 1'b1);
    wait_drain();
    check("count_wrap_model", BW'(dispatch_count), BW'(exp_count));
    check("count_wrap_zero", BW'(dispatch_count), BW'(0));
    push(8'hA5, 0, 1'b1);
    wait_drain();
    check("count_after_wrap", BW'(dispatch_count), BW'(1));
    core_done = 3'b000;
    nxt();
    check("wrap_busy_idle", BW'(core_busy), BW'(0));

    // Asynchronous reset while offering
    core_ready = 3'b000;
    push(8'h20, 1, 1'b0);
    nxt();
    check("pre_reset_offer", BW'(core_valid), BW'(3'b010));
    rst_n = 1'b0;
    #1;
    check("arst_valid", BW'(core_valid), BW'(0));
    check("arst_busy", BW'(core_busy), BW'(0));
    check("arst_count", BW'(dispatch_count), BW'(0));
    check("arst_hold_id", BW'(core_block_id), BW'(0));
    check("arst_ready", BW'(ready_out), BW'(1));
    @(negedge clk);
    rst_n     = 1'b1;
    exp_count = '0;
    nxt();
    check("post_reset_ready", BW'(ready_out), BW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
